// File: rtl/rom_fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rom_fetch_pkg : shared types and constants for rom_line_fetcher        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package rom_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    BUS  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int unsigned LINE_BYTES(input int unsigned wid, input int unsigned beats);
    return (wid / 8) * beats;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_line_fetcher_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rom_line_fetcher_if : request side and Wishbone side of the fetcher   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface rom_line_fetcher_if #(
  parameter int WID   = 128,
  parameter int BEATS = 4
);
  logic                   req_i;
  logic [17:0]            req_adr_i;
  logic                   busy_o;
  logic                   line_vld_o;
  logic [WID*BEATS-1:0]   line_o;
  logic                   err_o;
  logic                   cyc_o;
  logic                   stb_o;
  logic [2:0]             cti_o;
  logic [17:0]            adr_o;
  logic [WID-1:0]         dat_i;
  logic                   ack_i;

  modport master (
    input  req_i, req_adr_i, dat_i, ack_i,
    output busy_o, line_vld_o, line_o, err_o, cyc_o, stb_o, cti_o, adr_o
  );

  modport slave (
    output req_i, req_adr_i, dat_i, ack_i,
    input  busy_o, line_vld_o, line_o, err_o, cyc_o, stb_o, cti_o, adr_o
  );
endinterface
`default_nettype wire

// File: rtl/rom_line_fetcher.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rom_line_fetcher : Wishbone incrementing-burst master, one cache line |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rom_line_fetcher
  import rom_fetch_pkg::*;
#(
  parameter int WID   = 128,
  parameter int BEATS = 4,
  parameter int TMO   = 255
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  rom_line_fetcher_if.master    bus
);

  localparam int              c_BEAT_W     = $clog2(BEATS);
  localparam int              c_LINE_BYTES = LINE_BYTES(WID, BEATS);
  localparam logic [17:0]     c_ALIGN_MASK = 18'(c_LINE_BYTES - 1);
  localparam logic [17:0]     c_STEP       = 18'(WID / 8);
  localparam logic [c_BEAT_W-1:0] c_LAST   = c_BEAT_W'(BEATS - 1);
  localparam logic [7:0]      c_TMO_LAST   = 8'(TMO - 1);

  state_t                r_state;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [7:0]            r_tmo;
  logic [WID-1:0]        r_line [BEATS];
  logic                  r_cyc;
  logic                  r_busy;
  logic                  r_vld;
  logic                  r_err;
  logic [2:0]            r_cti;
  logic [17:0]           r_adr;

  logic [c_BEAT_W-1:0]   w_beat_nxt;

  assign w_beat_nxt = r_beat + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_tmo   <= '0;
      r_cyc   <= 1'b0;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_cti   <= CTI_CLASSIC;
      r_adr   <= '0;
      for (int i = 0; i < BEATS; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_i) begin
            r_adr   <= bus.req_adr_i & ~c_ALIGN_MASK;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
            r_cti   <= (BEATS == 1) ? CTI_EOB : CTI_INCR;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_state <= BUS;
          end
        end
        BUS: begin
          if (bus.ack_i) begin
            r_line[r_beat] <= bus.dat_i;
            r_adr          <= r_adr + c_STEP;
            r_tmo          <= '0;
            if (r_beat == c_LAST) begin
              // Drop the select on the final ack so the slave sees a fresh edge next fill.
              r_cyc   <= 1'b0;
              r_cti   <= CTI_CLASSIC;
              r_beat  <= '0;
              r_vld   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_beat <= w_beat_nxt;
              r_cti  <= (w_beat_nxt == c_LAST) ? CTI_EOB : CTI_INCR;
            end
          end else if (r_tmo == c_TMO_LAST) begin
            r_cyc   <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_tmo   <= r_tmo + 8'd1;
            r_err   <= 1'b1;
            r_state <= ERR;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        DONE, ERR: r_state <= GAP;
        GAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < BEATS; i++) begin : g_line
    assign bus.line_o[i*WID +: WID] = r_line[i];
  end

  assign bus.busy_o     = r_busy;
  assign bus.line_vld_o = r_vld;
  assign bus.err_o      = r_err;
  assign bus.cyc_o      = r_cyc;
  assign bus.stb_o      = r_cyc;
  assign bus.cti_o      = r_cti;
  assign bus.adr_o      = r_adr;

endmodule
`default_nettype wire

// File: doc/rom_line_fetcher.md
Name: rom_line_fetcher

Overview:
- Wishbone burst-read master that fills one instruction-cache line from the boot ROM (or any classic-cycle/incrementing-burst slave) per request.
- Sits between the I-cache miss logic and the ROM slave port.
- Issues an aligned incrementing burst of BEATS words of WID bits and assembles them into a line buffer.
- Presents the line with a one-cycle valid strobe, or flags a timeout error.

Parameters:
- WID, 128, data beat width in bits; the slave returns one WID word per ack.
- BEATS, 4, beats per line; power of two, 2..8.
- TMO, 255, maximum cycles to wait for any single ack before aborting; 8-bit counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  line fill request; sampled only in IDLE
- req_adr_i  in  18  byte address of the miss; low log2(BEATS)+4 bits ignored
- busy_o  out  1  high from request acceptance until return to IDLE
- line_vld_o  out  1  one-cycle strobe: line_o is valid
- line_o  out  WID*BEATS  assembled line; beat 0 in bits [WID-1:0]
- err_o  out  1  one-cycle strobe: fill aborted on timeout
- cyc_o  out  1  bus cycle
- stb_o  out  1  strobe
- cti_o  out  3  010 = incrementing burst, 111 = end of burst
- adr_o  out  18  beat byte address, 16-byte aligned
- dat_i  in  WID  read data
- ack_i  in  1  slave acknowledge

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE. cyc_o, stb_o, busy_o, line_vld_o and err_o are 0. cti_o=000, adr_o=0, line_o=0, beat counter=0, timeout counter=0.
- States: IDLE, GAP, BUS, DONE, ERR.
- IDLE:
  - On req_i=1, latch the line base = req_adr_i with the low log2(BEATS)+4 bits cleared.
  - Go to BUS and set busy_o=1.
  - Next cycle: cyc_o=stb_o=1, adr_o=base, cti_o=010.
  - With BEATS=1 (not allowed) cti would be 111; for all legal BEATS the first beat is 010.
- BUS:
  - On each cycle with ack_i=1, write dat_i into line slot [beat], increment beat, add 16 to adr_o, and clear the timeout counter.
  - While beat+1 == BEATS-1 after the increment, drive cti_o=111.
  - Acks may arrive back to back; there is no wait state after the first ack.
  - On the ack of beat BEATS-1, drop cyc_o/stb_o in the same edge and go to DONE.
  - The slave detects a new transaction on the rising edge of its select, so cyc_o must not remain asserted across fills.
- Timeout: the counter increments on every BUS cycle without ack_i. When it reaches TMO, drop cyc_o/stb_o and go to ERR. Partial line data is retained but never flagged valid.
- DONE: line_vld_o=1 for exactly one cycle; line_o is held stable until the next fill writes beat 0. Go to GAP.
- ERR: err_o=1 for one cycle; go to GAP.
- GAP: one mandatory idle cycle with cyc_o=0. busy_o=0 and return to IDLE. A req_i asserted during DONE/ERR/GAP is ignored; the requester must hold req_i until busy_o rises.
- busy_o is 1 in BUS, DONE, ERR and GAP.
- Address arithmetic: 18-bit, wraps mod 2^18. Because the base is line-aligned, no wrap occurs within a line except at the top of space (0x3FFF0 -> 0x00000), which is allowed.
- A stray ack_i outside BUS is ignored.
- Reset asserted mid-burst: cyc_o drops asynchronously, the line is discarded, no strobe is issued.

Decomposition:
- Shared package rom_fetch_pkg holds:
  - the state enum (IDLE, GAP, BUS, DONE, ERR);
  - the CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - the LINE_BYTES function of WID and BEATS.
- No sub-module; the line buffer is a register array indexed by the beat counter.

Test Plan:
- Reset check: with rst_ni=0, every output is 0 and cti_o=000; rst_ni=1 with req_i=0 for 10 cycles leaves all outputs unchanged.
- Aligned fill:
  - Stimulus: req_adr_i=0x00140; ROM model acks with 2-cycle initial latency, then every cycle.
  - Required: adr_o sequence 0x00140, 0x00150, 0x00160, 0x00170; cti_o 010, 010, 010, 111; one line_vld_o pulse; line_o equals the 4 model words.
  - Required: cyc_o is low for at least one cycle before the next fill.
- Unaligned request: req_adr_i=0x0015C -> burst starts at 0x00140; same line as the aligned case.
- Stalled slave: acks with a 3-cycle gap between beats -> the line is still correct and the timeout never fires.
- Timeout: the slave never acks -> cyc_o drops after exactly TMO=255 cycles, err_o pulses once, line_vld_o stays 0, busy_o falls one cycle later.
- Top-of-space wrap and mid-burst reset:
  - req_adr_i=0x3FFC0 -> last adr_o is 0x3FFF0 and the fill completes.
  - rst_ni pulsed low after beat 1 -> cyc_o low immediately, no strobes, and the next request fills correctly.
